matrix_result_sender: RTL and testbench

- Transmit-side counterpart of the host-facing receive path.
- Once multiplication completes, reads the N×N result matrix from the result buffer and serialises it to the UART transmitter.
- Byte order: one header byte (N), then each 16-bit element as two bytes, MSB first, row-major.
- Single-byte `tx_start`/`tx_busy` handshake with the UART TX; pulses `done` when the last byte is accepted.

---
 rtl/matrix_result_sender.sv | 173 +++++++++++++++++
 tb/tb_matrix_result_sender.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_sender.sv
// matrix_result_sender: streams an N x N result matrix to a byte UART.
// Sends header byte N, then each 16-bit element MSB-first, row-major.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         one-cycle pulse, accepted only when idle
//   matrix_size   N, sampled with an accepted start
//   rd_en         result buffer read strobe
//   rd_addr       result buffer address (element index)
//   rd_data       buffer data, valid one cycle after rd_en
//   tx_start      one-cycle pulse, tx_data valid, begin a byte
//   tx_data       byte to transmit, held until the next tx_start
//   tx_busy       UART TX busy
//   busy          transfer in progress
//   done          one-cycle pulse at end of transfer
module matrix_result_sender #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int MAX_N  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        WAIT_HDR,
        FETCH,
        LATCH,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        FINISH
    } state_t;

    localparam logic [4:0] MAX_N_W = 5'(MAX_N);

    state_t      state;
    state_t      state_next;
    logic [3:0]  n_reg;
    logic [7:0]  total;
    logic [7:0]  index;
    logic [15:0] elem;
    logic [7:0]  tx_hold;
    logic [7:0]  tx_byte;
    logic        guard;
    logic        idx_inc;
    logic        hdr_only;
    logic        last;
    logic        byte_done;

    assign hdr_only = (n_reg == 4'd0) || ({1'b0, n_reg} > MAX_N_W);
    assign last     = (index == total - 8'd1);
    // The guard cycle right after tx_start ignores tx_busy so a TX that
    // raises busy one cycle late is not mistaken for an idle one.
    assign byte_done = !guard && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n_reg   <= 4'd0;
            total   <= 8'd0;
            index   <= 8'd0;
            elem    <= 16'd0;
            tx_hold <= 8'd0;
            guard   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                n_reg <= matrix_size;
                total <= 8'(matrix_size) * 8'(matrix_size);
                index <= 8'd0;
            end
            if (state == LATCH) begin
                elem <= rd_data[15:0];
            end
            if (idx_inc) begin
                index <= index + 8'd1;
            end
            if (tx_start) begin
                tx_hold <= tx_byte;
            end
            guard <= tx_start;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        rd_en      = 1'b0;
        idx_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_byte    = {4'b0000, n_reg};
                    state_next = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (byte_done) begin
                    state_next = hdr_only ? FINISH : FETCH;
                end
            end
            FETCH: begin
                rd_en      = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                state_next = SEND_HI;
            end
            SEND_HI: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_byte    = elem[15:8];
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (byte_done) begin
                    state_next = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_byte    = elem[7:0];
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_done) begin
                    if (last) begin
                        state_next = FINISH;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_addr = ADDR_W'(index);
    assign tx_data = tx_start ? tx_byte : tx_hold;
    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH);

endmodule

// File: tb/tb_matrix_result_sender.sv
// tb_matrix_result_sender: directed bench with a stream-level model of
// the expected byte sequence and buffer reads, checked every cycle.
module tb_matrix_result_sender;

    localparam int MAXN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  matrix_size;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        busy;
    logic        done;

    matrix_result_sender #(
        .DATA_W(16),
        .ADDR_W(8),
        .MAX_N (MAXN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matrix_size(matrix_size),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Result buffer: one-cycle read latency.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // UART TX model: busy for tx_len cycles, optionally one cycle late.
    int tx_len  = 10;
    bit tx_late = 1'b0;
    int cnt     = 0;
    bit dly     = 1'b0;
    always @(posedge clk) begin
        if (tx_start && tx_len > 0) begin
            cnt <= tx_len;
            dly <= tx_late;
        end else if (dly) begin
            dly <= 1'b0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end
    assign tx_busy = (cnt > 0) && !dly;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    // Stream-level model: what a transfer of size n must produce.
    logic [7:0] exp_bytes[$];
    int         exp_reads[$];
    logic [7:0] log_b[$];
    int         reads_log[$];
    int         done_cnt = 0;
    bit         in_xfer  = 1'b0;
    bit         prev_txs = 1'b0;

    task automatic load_model(input logic [3:0] n);
        int nn;
        exp_bytes.push_back({4'b0000, n});
        if (n != 0 && int'(n) <= MAXN) begin
            nn = int'(n) * int'(n);
            for (int i = 0; i < nn; i++) begin
                exp_bytes.push_back(mem[i][15:8]);
                exp_bytes.push_back(mem[i][7:0]);
                exp_reads.push_back(i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_xfer  = 1'b0;
            prev_txs = 1'b0;
            exp_bytes.delete();
            exp_reads.delete();
        end else begin
            if (tx_start) begin
                chk("tx_start_while_busy", int'(tx_busy), 0);
                chk("tx_start_adjacent", int'(prev_txs), 0);
                log_b.push_back(tx_data);
                chk("byte_expected", int'(exp_bytes.size() > 0), 1);
                if (exp_bytes.size() > 0)
                    chk("tx_byte", int'(tx_data), int'(exp_bytes.pop_front()));
            end
            prev_txs = tx_start;
            if (rd_en) begin
                reads_log.push_back(int'(rd_addr));
                chk("read_expected", int'(exp_reads.size() > 0), 1);
                if (exp_reads.size() > 0)
                    chk("rd_addr", int'(rd_addr), exp_reads.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("done_in_xfer", int'(in_xfer), 1);
                chk("busy_at_done", int'(busy), 0);
                chk("bytes_left", exp_bytes.size(), 0);
                chk("reads_left", exp_reads.size(), 0);
                in_xfer = 1'b0;
            end else begin
                chk("busy", int'(busy), int'(in_xfer));
                if (start && !in_xfer) begin
                    in_xfer = 1'b1;
                    load_model(matrix_size);
                end
            end
        end
    end

    task automatic do_start(input logic [3:0] n);
        @(posedge clk);
        #1 start = 1'b1;
        matrix_size = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_rd_en"}, int'(rd_en), 0);
        chk({nm, "_rd_addr"}, int'(rd_addr), 0);
        chk({nm, "_tx_start"}, int'(tx_start), 0);
        chk({nm, "_tx_data"}, int'(tx_data), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
    endtask

    logic [7:0] lit2 [9] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD,
                             8'h00, 8'h01, 8'hFF, 8'h00};

    task automatic chk_lit2(input string nm);
        chk({nm, "_count"}, log_b.size(), 9);
        for (int i = 0; i < 9 && i < log_b.size(); i++)
            chk({nm, "_byte"}, int'(log_b[i]), int'(lit2[i]));
    endtask

    task automatic load_mem2();
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        mem[2] = 16'h0001;
        mem[3] = 16'hFF00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        rst = 1'b1;
        start = 1'b0;
        matrix_size = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // N=2, slow TX
        load_mem2();
        log_b.delete();
        done_cnt = 0;
        do_start(4'd2);
        wait_done(1000, "n2");
        settle();
        chk_lit2("n2");
        chk("n2_done_cnt", done_cnt, 1);

        // N=3, tx_busy tied low
        tx_len = 0;
        for (int i = 0; i < 9; i++) mem[i] = 16'(i * 16'h0101 + 16'h0A05);
        log_b.delete();
        reads_log.delete();
        do_start(4'd3);
        wait_done(500, "n3");
        settle();
        chk("n3_byte_count", log_b.size(), 19);
        chk("n3_read_count", reads_log.size(), 9);
        for (int i = 0; i < 9 && i < reads_log.size(); i++)
            chk("n3_read_order", reads_log[i], i);
        chk("n3_first_elem_hi", (log_b.size() > 1) ? int'(log_b[1]) : -1, 'h0A);
        chk("n3_last_elem_lo", (log_b.size() > 18) ? int'(log_b[18]) : -1, 'h0D);

        // Header-only transfers
        tx_len = 10;
        log_b.delete();
        reads_log.delete();
        done_cnt = 0;
        do_start(4'd0);
        wait_done(200, "n0");
        settle();
        chk("n0_count", log_b.size(), 1);
        chk("n0_hdr", (log_b.size() > 0) ? int'(log_b[0]) : -1, 'h00);
        log_b.delete();
        do_start(4'd5);
        wait_done(200, "n5");
        settle();
        chk("n5_count", log_b.size(), 1);
        chk("n5_hdr", (log_b.size() > 0) ? int'(log_b[0]) : -1, 'h05);
        chk("hdr_only_reads", reads_log.size(), 0);
        chk("hdr_only_done_cnt", done_cnt, 2);

        // Second start mid-transfer is ignored
        load_mem2();
        log_b.delete();
        done_cnt = 0;
        do_start(4'd2);
        repeat (20) @(posedge clk);
        do_start(4'd3);
        wait_done(1000, "restart");
        repeat (10) settle();
        chk_lit2("restart");
        chk("restart_done_cnt", done_cnt, 1);

        // Reset after the third byte
        log_b.delete();
        do_start(4'd2);
        reached = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (log_b.size() >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        chk("rst_third_byte_seen", int'(reached), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        repeat (30) settle();
        chk("midrst_no_more_bytes", log_b.size(), 3);
        log_b.delete();
        done_cnt = 0;
        do_start(4'd2);
        wait_done(1000, "after_rst");
        settle();
        chk_lit2("after_rst");
        chk("after_rst_done_cnt", done_cnt, 1);

        // TX raising busy one cycle late; then start colliding with done
        tx_len = 6;
        tx_late = 1'b1;
        log_b.delete();
        do_start(4'd2);
        wait_done(1000, "late");
        #1 start = 1'b1;
        matrix_size = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        chk_lit2("late");
        log_b.delete();
        wait_done(200, "collide");
        settle();
        chk("collide_count", log_b.size(), 1);
        chk("collide_hdr", (log_b.size() > 0) ? int'(log_b[0]) : -1, 'h00);

        repeat (5) settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
